// File: rtl/cadu_pkg.sv
// Shared state encoding, sync-marker constant and popcount helper for the CADU sync path.
package cadu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQUIRE,
        WAIT_RESULT,
        SKIP,
        TRACK
    } state_t;

    localparam logic [31:0] CADU_SYNC_WORD = 32'h1ACFFC1D;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/cadu_sync_ctrl_uw_check.sv
// Sync-word checker: shifts in the first 32 bits of a frame, then flags good/bad one cycle after the 32nd bit.
// No backpressure; bits are taken whenever shift is high.
module uw_check
    import cadu_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD    = CADU_SYNC_WORD,
    parameter int          MAX_SYNC_ERR = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic din,
    input  logic last,
    output logic vld,
    output logic good
);

    logic [31:0] sr;
    logic [31:0] sr_nxt;

    assign sr_nxt = {sr[30:0], din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            vld  <= 1'b0;
            good <= 1'b0;
        end else begin
            vld <= shift && last;
            if (shift) sr <= sr_nxt;
            // Compare against the word including the bit arriving this cycle.
            if (shift && last) good <= (popcount32(sr_nxt ^ SYNC_WORD) <= 6'(MAX_SYNC_ERR));
        end
    end

endmodule

// File: rtl/cadu_sync_ctrl.sv
// CADU frame sync sequencer: acquire via external correlator, align to its offset, track and re-check the sync word.
// Bit paths have 1-cycle latency; valid_in low stalls all counters, there is no downstream backpressure.
module cadu_sync_ctrl
    import cadu_pkg::*;
#(
    parameter int          BITS_PER_FRAME = 8192,
    parameter int          NUM_FRAMES     = 8,
    parameter logic [31:0] SYNC_WORD      = CADU_SYNC_WORD,
    parameter int          MAX_SYNC_ERR   = 3,
    parameter int          MISS_LIMIT     = 4,
    localparam int         POS_W          = $clog2(BITS_PER_FRAME),
    localparam int         MISS_W         = $clog2(MISS_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              hard_inp,
    input  logic              valid_in,
    output logic              corr_hard_out,
    output logic              corr_valid_out,
    input  logic              corr_ready_rx,
    input  logic              corr_done,
    input  logic [POS_W-1:0]  corr_offset,
    output logic              bit_out,
    output logic              bit_valid_out,
    output logic              frame_start_out,
    output logic              locked_out,
    output logic [MISS_W-1:0] miss_count_out
);

    localparam int ACQ_BITS = NUM_FRAMES * BITS_PER_FRAME;
    localparam int ACQ_W    = $clog2(ACQ_BITS);

    state_t           state;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_nxt;
    logic [POS_W-1:0] off_q;
    logic [POS_W-1:0] frm_idx;
    logic [ACQ_W-1:0] acq_cnt;
    logic             at_start;
    logic             at_end;
    logic             done_hit;
    logic             uw_shift;
    logic             uw_last;
    logic             uw_vld;
    logic             uw_good;

    always_comb begin
        pos_nxt = (pos == POS_W'(BITS_PER_FRAME - 1)) ? '0 : pos + 1'b1;
        // Bit index within the frame, wrapped modulo the frame length.
        if (pos >= off_q) frm_idx = pos - off_q;
        else              frm_idx = pos + POS_W'(BITS_PER_FRAME) - off_q;
        at_start = (pos == off_q);
        at_end   = (frm_idx == POS_W'(BITS_PER_FRAME - 1));
        done_hit = corr_done && valid_in && (pos == corr_offset);
        uw_shift = 1'b0;
        uw_last  = 1'b0;
        case (state)
            WAIT_RESULT: uw_shift = done_hit;
            SKIP:        uw_shift = valid_in && at_start;
            TRACK: begin
                uw_shift = valid_in && (frm_idx < POS_W'(32));
                uw_last  = (frm_idx == POS_W'(31));
            end
            default: ;
        endcase
    end

    uw_check #(
        .SYNC_WORD    (SYNC_WORD),
        .MAX_SYNC_ERR (MAX_SYNC_ERR)
    ) u_uw_check (
        .clk   (clk),
        .rst   (rst_in),
        .shift (uw_shift),
        .din   (hard_inp),
        .last  (uw_last),
        .vld   (uw_vld),
        .good  (uw_good)
    );

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            pos             <= '0;
            off_q           <= '0;
            acq_cnt         <= '0;
            corr_hard_out   <= 1'b0;
            corr_valid_out  <= 1'b0;
            bit_out         <= 1'b0;
            bit_valid_out   <= 1'b0;
            frame_start_out <= 1'b0;
            locked_out      <= 1'b0;
            miss_count_out  <= '0;
        end else begin
            corr_valid_out  <= 1'b0;
            bit_valid_out   <= 1'b0;
            frame_start_out <= 1'b0;
            if (valid_in && state != IDLE) pos <= pos_nxt;
            case (state)
                IDLE: begin
                    if (corr_ready_rx) begin
                        state   <= ACQUIRE;
                        pos     <= '0;
                        acq_cnt <= '0;
                    end
                end
                ACQUIRE: begin
                    corr_valid_out <= valid_in;
                    if (valid_in) begin
                        corr_hard_out <= hard_inp;
                        acq_cnt       <= acq_cnt + 1'b1;
                        if (acq_cnt == ACQ_W'(ACQ_BITS - 1)) state <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    if (corr_done) begin
                        off_q <= corr_offset;
                        if (done_hit) begin
                            bit_out         <= hard_inp;
                            bit_valid_out   <= 1'b1;
                            frame_start_out <= 1'b1;
                            locked_out      <= 1'b1;
                            state           <= TRACK;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (valid_in && at_start) begin
                        bit_out         <= hard_inp;
                        bit_valid_out   <= 1'b1;
                        frame_start_out <= 1'b1;
                        locked_out      <= 1'b1;
                        state           <= TRACK;
                    end
                end
                TRACK: begin
                    if (uw_vld) begin
                        if (uw_good) miss_count_out <= '0;
                        else if (miss_count_out != MISS_W'(MISS_LIMIT))
                            miss_count_out <= miss_count_out + 1'b1;
                    end
                    if (valid_in) begin
                        bit_out         <= hard_inp;
                        bit_valid_out   <= 1'b1;
                        frame_start_out <= at_start;
                        // Lock is dropped only once the frame holding the final miss has gone out.
                        if (at_end && miss_count_out == MISS_W'(MISS_LIMIT)) begin
                            locked_out     <= 1'b0;
                            miss_count_out <= '0;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cadu_sync_ctrl.sv
// Bench for cadu_sync_ctrl with short frames; it plays the correlator and models the aligned output stream.
module tb_cadu_sync_ctrl;

    localparam int BPF   = 128;
    localparam int NF    = 2;
    localparam int TOTAL = BPF * NF;
    localparam int MAXE  = 3;
    localparam int MISS  = 4;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       hard_inp;
    logic       valid_in;
    logic       corr_hard_out;
    logic       corr_valid_out;
    logic       corr_ready_rx;
    logic       corr_done;
    logic [6:0] corr_offset;
    logic       bit_out;
    logic       bit_valid_out;
    logic       frame_start_out;
    logic       locked_out;
    logic [2:0] miss_count_out;

    int   total = 0;
    int   bad   = 0;
    bit   fed[$];
    bit   cap[$];
    bit   obit[$];
    bit   ofs[$];
    int   flips[16];
    logic rdy_q = 1'b0;
    logic [31:0] sw = 32'h1ACFFC1D;

    always #5 clk = ~clk;

    cadu_sync_ctrl #(
        .BITS_PER_FRAME (BPF),
        .NUM_FRAMES     (NF),
        .SYNC_WORD      (32'h1ACFFC1D),
        .MAX_SYNC_ERR   (MAXE),
        .MISS_LIMIT     (MISS)
    ) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .hard_inp        (hard_inp),
        .valid_in        (valid_in),
        .corr_hard_out   (corr_hard_out),
        .corr_valid_out  (corr_valid_out),
        .corr_ready_rx   (corr_ready_rx),
        .corr_done       (corr_done),
        .corr_offset     (corr_offset),
        .bit_out         (bit_out),
        .bit_valid_out   (bit_valid_out),
        .frame_start_out (frame_start_out),
        .locked_out      (locked_out),
        .miss_count_out  (miss_count_out)
    );

    always @(posedge clk) rdy_q <= corr_ready_rx;

    // Correlator side and output capture.
    always @(negedge clk) begin
        if (corr_valid_out === 1'b1) begin
            cap.push_back(corr_hard_out);
            total++;
            assert (rdy_q === 1'b1)
            else begin
                bad++;
                $error("FAIL proto_ready observed=%b expected=1", rdy_q);
            end
        end
        if (bit_valid_out === 1'b1) begin
            obit.push_back(bit_out);
            ofs.push_back(frame_start_out);
        end
    end

    function automatic logic rnd();
        return ($urandom & 1) != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic d);
        valid_in  = v;
        hard_inp  = b;
        corr_done = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int id);
        rst_in = 1'b1;
        #1;
        chk($sformatf("s%0d_reset_outs", id),
            32'({corr_hard_out, corr_valid_out, bit_out, bit_valid_out,
                 frame_start_out, locked_out, miss_count_out}), 32'd0);
        valid_in      = 1'b0;
        corr_done     = 1'b0;
        corr_ready_rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic session(input int id, input int o, input bit gaps, input int ntrack);
        int          s0, s_end, lost_frame, m, nexp, errs, fserr;
        logic [31:0] w;
        do_reset(id);
        cap.delete(); fed.delete(); obit.delete(); ofs.delete();
        corr_offset = '0;
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0);
        chk($sformatf("s%0d_idle_drop", id), cap.size(), 0);
        corr_ready_rx = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        s0         = TOTAL + ((o - (TOTAL % BPF) + BPF) % BPF);
        s_end      = s0 + ntrack * BPF + 8;
        m          = 0;
        lost_frame = -1;
        for (int s = 0; s < s_end; s++) begin
            int idx, fr;
            bit b;
            if (s == TOTAL + 1) corr_ready_rx = 1'b0;
            if (gaps) for (int k = 0; k < 3 && rnd(); k++) step(1'b0, rnd(), 1'b0);
            idx = (s + BPF - o) % BPF;
            fr  = (s >= s0) ? (s - s0) / BPF : -1;
            if (idx < 32) begin
                b = sw[31-idx];
                if (fr >= 0 && idx < flips[fr]) b = ~b;
            end else begin
                b = rnd();
            end
            fed.push_back(b);
            if (s == TOTAL) corr_offset = 7'(o);
            step(1'b1, b, s == TOTAL);
            if (fr >= 0 && idx == 40 && lost_frame < 0) begin
                if (flips[fr] > MAXE) m++;
                else m = 0;
                if (m == MISS) lost_frame = fr;
                else begin
                    chk($sformatf("s%0d_f%0d_miss", id, fr), 32'(miss_count_out), m);
                    chk($sformatf("s%0d_f%0d_locked", id, fr), 32'(locked_out), 1);
                end
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        nexp = (lost_frame >= 0) ? (lost_frame + 1) * BPF : s_end - s0;
        chk($sformatf("s%0d_acq_count", id), cap.size(), TOTAL);
        errs = 0;
        for (int i = 0; i < cap.size() && i < TOTAL; i++) if (cap[i] != fed[i]) errs++;
        chk($sformatf("s%0d_acq_bits", id), errs, 0);
        chk($sformatf("s%0d_out_count", id), obit.size(), nexp);
        errs  = 0;
        fserr = 0;
        for (int i = 0; i < obit.size() && i < nexp; i++) begin
            if (obit[i] != fed[s0+i]) errs++;
            if (ofs[i] != ((i % BPF) == 0)) fserr++;
        end
        chk($sformatf("s%0d_out_bits", id), errs, 0);
        chk($sformatf("s%0d_frame_starts", id), fserr, 0);
        w = '0;
        for (int i = 0; i < 32 && i < obit.size(); i++) w = {w[30:0], obit[i]};
        chk($sformatf("s%0d_first_word", id), w, sw ^ ~(32'hFFFFFFFF >> flips[0]));
        chk($sformatf("s%0d_final_locked", id), 32'(locked_out), (lost_frame < 0) ? 1 : 0);
        if (lost_frame >= 0)
            chk($sformatf("s%0d_final_miss", id), 32'(miss_count_out), 0);
    endtask

    task automatic abort_acq(input int id);
        do_reset(id);
        corr_ready_rx = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, rnd(), 1'b0);
        chk($sformatf("s%0d_mid_acq_cvld", id), 32'(corr_valid_out), 1);
    endtask

    task automatic clear_flips();
        for (int i = 0; i < 16; i++) flips[i] = 0;
    endtask

    initial begin
        rst_in        = 1'b1;
        valid_in      = 1'b0;
        hard_inp      = 1'b0;
        corr_ready_rx = 1'b0;
        corr_done     = 1'b0;
        corr_offset   = '0;
        clear_flips();
        @(negedge clk);
        session(1, 0, 1'b0, 3);
        session(2, 1, 1'b0, 2);
        session(3, BPF/2 - 1, 1'b0, 2);
        session(4, BPF - 1, 1'b0, 2);
        flips[0] = 3; flips[1] = 3;
        session(5, 37, 1'b0, 3);
        clear_flips();
        flips[1] = 4; flips[3] = 4; flips[4] = 4; flips[5] = 4; flips[6] = 4;
        session(6, 5, 1'b0, 7);
        clear_flips();
        session(7, 90, 1'b1, 3);
        abort_acq(8);
        session(9, BPF - 1, 1'b1, 2);
        session(10, 90, 1'b0, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
